// File: rtl/put_in_order_unit.sv
// Reorder stage: collects results from n_inputs round-robin lanes with unequal
// latencies and re-emits them as a single stream in original issue order.
module put_in_order_unit #(
  parameter int width    = 16,
  parameter int n_inputs = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [n_inputs-1:0]                up_vlds,
  input  logic [n_inputs-1:0][width-1:0]     up_data,
  output logic                               down_vld,
  output logic [width-1:0]                   down_data
);

  localparam int PTR_W = (n_inputs > 1) ? $clog2(n_inputs) : 1;
  localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(n_inputs - 1);

  logic [n_inputs-1:0]             buf_vld_q,  buf_vld_d;
  logic [n_inputs-1:0][width-1:0]  buf_data_q, buf_data_d;
  logic [PTR_W-1:0]                exp_ptr_q,  exp_ptr_d;
  logic                            down_vld_q, down_vld_d;
  logic [width-1:0]                down_data_q, down_data_d;
  logic                            avail;

  always_comb begin
    buf_vld_d   = buf_vld_q;
    buf_data_d  = buf_data_q;
    exp_ptr_d   = exp_ptr_q;
    down_vld_d  = 1'b0;
    down_data_d = down_data_q;
    avail       = buf_vld_q[exp_ptr_q] | up_vlds[exp_ptr_q];

    for (int j = 0; j < n_inputs; j++) begin
      if (PTR_W'(j) == exp_ptr_q) begin
        // Expected lane: an empty buffer lets the word bypass; a full one is
        // drained now and refilled by any word arriving in the same cycle.
        if (buf_vld_q[j]) begin
          buf_vld_d[j] = up_vlds[j];
          if (up_vlds[j]) begin
            buf_data_d[j] = up_data[j];
          end
        end
      end else if (up_vlds[j]) begin
        buf_vld_d[j]  = 1'b1;
        buf_data_d[j] = up_data[j];
      end
    end

    if (avail) begin
      down_vld_d  = 1'b1;
      down_data_d = buf_vld_q[exp_ptr_q] ? buf_data_q[exp_ptr_q] : up_data[exp_ptr_q];
      exp_ptr_d   = (exp_ptr_q == LAST_LANE) ? '0 : exp_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_vld_q   <= '0;
      exp_ptr_q   <= '0;
      down_vld_q  <= 1'b0;
      down_data_q <= '0;
    end else begin
      buf_vld_q   <= buf_vld_d;
      exp_ptr_q   <= exp_ptr_d;
      down_vld_q  <= down_vld_d;
      down_data_q <= down_data_d;
    end
  end

  // Holding-register contents are only meaningful while buf_vld is set.
  always_ff @(posedge clk) begin
    buf_data_q <= buf_data_d;
  end

  assign down_vld  = down_vld_q;
  assign down_data = down_data_q;

endmodule

// File: tb/tb_put_in_order_unit.sv
// Scoreboard bench for put_in_order_unit: issue-order reference model with
// per-item arrival times, checked by an independent output monitor.
module tb_put_in_order_unit;
  localparam int W = 16;
  localparam int N = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N-1:0]           up_vlds = '0;
  logic [N-1:0][W-1:0]    up_data = '0;
  logic                   down_vld;
  logic [W-1:0]           down_data;

  put_in_order_unit #(.width(W), .n_inputs(N)) dut (
    .clk(clk), .rst(rst), .up_vlds(up_vlds), .up_data(up_data),
    .down_vld(down_vld), .down_data(down_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int passes = 0;
  int issued = 0;
  int last_out = 0;
  logic [W-1:0] dcnt = '0;

  // Arrival schedule keyed by cycle number, and the expected output stream.
  logic [N-1:0]        arr_v [int];
  logic [N-1:0][W-1:0] arr_d [int];
  logic [W-1:0]        exp_data [$];
  int                  exp_cyc  [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s at cycle %0d: got %0h required %0h", name, cyc, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (arr_v.exists(cyc)) begin
      up_vlds = arr_v[cyc];
      up_data = arr_d[cyc];
      arr_v.delete(cyc);
      arr_d.delete(cyc);
    end else begin
      up_vlds = '0;
    end
  endtask

  task automatic put_arrival(input int at, input int lane, input logic [W-1:0] data);
    if (!arr_v.exists(at)) begin
      arr_v[at] = '0;
      arr_d[at] = '0;
    end
    arr_v[at][lane] = 1'b1;
    arr_d[at][lane] = data;
  endtask

  // Item is issued next cycle on lane issued%N and returns d cycles later.
  // It leaves one cycle after it arrives, but never before its predecessor.
  task automatic issue_next(input int d);
    int at;
    int o;
    at = cyc + 1 + d;
    put_arrival(at, issued % N, dcnt);
    o = (at + 1 > last_out + 1) ? at + 1 : last_out + 1;
    last_out = o;
    exp_data.push_back(dcnt);
    exp_cyc.push_back(o);
    issued++;
    dcnt = dcnt + 1'b1;
    step();
  endtask

  task automatic pad_to(input int r);
    while (issued % N != r) issue_next(0);
  endtask

  task automatic drain(input string name);
    repeat (N + 2) step();
    chk(name, exp_data.size(), 0);
  endtask

  // Output monitor: decoupled from stimulus, compares against queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        logic exp_v;
        exp_v = (exp_cyc.size() > 0) && (exp_cyc[0] == cyc);
        chk("down_vld", down_vld, exp_v);
        if (exp_v && down_vld === 1'b1) chk("down_data", down_data, exp_data[0]);
        if (exp_cyc.size() > 0 && exp_cyc[0] <= cyc) begin
          void'(exp_data.pop_front());
          void'(exp_cyc.pop_front());
        end
      end
    end
  end

  initial begin
    #1 rst = 1'b0;
    repeat (3) step();
    chk("reset_vld", down_vld, 0);
    chk("reset_data", down_data, 0);
    #1 rst = 1'b1;
    last_out = cyc;

    for (int i = 0; i < 8; i++) issue_next(0);
    drain("drain_zero_delay");

    for (int i = 0; i < 4; i++) issue_next(3 - i);
    drain("drain_reversal");

    for (int combo = 0; combo < 256; combo++)
      for (int l = 0; l < N; l++) issue_next((combo >> (2 * l)) & 3);
    drain("drain_exhaustive");

    pad_to(0);
    issue_next(0);
    issue_next(1);
    repeat (5) step();
    for (int i = 0; i < 6; i++) issue_next(i % N);
    pad_to(0);
    drain("drain_idle_gap");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      else issue_next(int'($urandom_range(0, N - 1)));
    end
    drain("drain_random");

    // Lane 3 finishes the round while lane 0 of the next round is slow and
    // lanes 1 and 2 sit buffered; reset lands while lane 3's word is shown.
    pad_to(3);
    issue_next(3);
    issue_next(3);
    issue_next(0);
    issue_next(0);
    step();
    chk("pre_reset_vld", down_vld, (exp_cyc.size() > 0) && (exp_cyc[0] == cyc));
    rst = 1'b0;
    #1;
    chk("reset_async_vld", down_vld, 0);
    chk("reset_async_data", down_data, 0);
    exp_data.delete();
    exp_cyc.delete();
    arr_v.delete();
    arr_d.delete();
    issued = 0;
    up_vlds = '0;
    repeat (2) step();
    #1 rst = 1'b1;
    last_out = cyc;
    issue_next(0);
    issue_next(0);
    drain("drain_after_reset");

    pad_to(0);
    drain("drain_before_overwrite");
    begin
      int a;
      a = cyc + 1;
      put_arrival(a,     2, 16'hA001);
      put_arrival(a + 1, 2, 16'hA002);
      put_arrival(a + 2, 0, 16'hB000);
      put_arrival(a + 3, 1, 16'hB001);
      exp_data.push_back(16'hB000); exp_cyc.push_back(a + 3);
      exp_data.push_back(16'hB001); exp_cyc.push_back(a + 4);
      exp_data.push_back(16'hA002); exp_cyc.push_back(a + 5);
      repeat (4) step();
    end
    drain("drain_overwrite");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
